// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
//   mem_size_t  : access size encoding carried on mem_size_m
//   mem_state_t : MEM stage handshake FSM states
//   byte_enable / is_misaligned : lane helpers shared by the stage
package mips_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

    // Byte enables for an access; the reserved size behaves as a word.
    function automatic logic [BE_W-1:0] byte_enable(input logic [1:0] size,
                                                     input logic [LANE_W-1:0] lane);
        if (size == SIZE_BYTE) return BE_BYTE0 << lane;
        if (size == SIZE_HALF) return lane[1] ? BE_HALF_HI : BE_HALF_LO;
        return BE_WORD;
    endfunction

    // Half needs an even address, word (and reserved) needs a word-aligned one.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [LANE_W-1:0] lane);
        if (size == SIZE_BYTE) return 1'b0;
        if (size == SIZE_HALF) return lane[0];
        return lane != '0;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data aligner: picks the addressed byte/half out of a read word and
// sign- or zero-extends it to 32 bits.
//   rdata       : raw word from memory (or the stage's read buffer)
//   lane        : address bits [1:0]
//   size        : 0=byte 1=half 2/3=word
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   aligned_c   : aligned and extended result (combinational)
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [LANE_W-1:0] lane,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] aligned_c
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte  = rdata[{lane, 3'b000} +: 8];
        sel_half  = rdata[{lane[1], 4'b0000} +: 16];
        aligned_c = rdata;
        if (size == SIZE_BYTE) begin
            aligned_c = is_unsigned ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
        end else if (size == SIZE_HALF) begin
            aligned_c = is_unsigned ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs the data-memory req/ack handshake for loads and
// stores, aligns load data and drives the MEM/WB register inputs. stall_m
// freezes all upstream stages while an access is outstanding.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   *_m inputs                  : EX/MEM register outputs
//   dmem_req/we/addr/wdata/be   : memory request, held until dmem_ack
//   dmem_ack/rdata              : memory completion and read word
//   *_mw outputs                : MEM/WB register inputs
//   stall_m, misalign_m, bus_error_m : pipeline freeze and 1-cycle fault flags
// Parameters: TIMEOUT_CYCLES = max WAIT cycles; 2**CNT_W must exceed it.
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_out_m,
    input  logic [DATA_W-1:0] write_data_m,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [1:0]        mem_size_m,
    input  logic              mem_unsigned_m,
    input  logic              wb_source_m,
    input  logic              reg_write_m,
    input  logic [REG_W-1:0]  register_d_m,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [BE_W-1:0]   dmem_be,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] alu_out_mw,
    output logic [DATA_W-1:0] data_mw,
    output logic              wb_source_mw,
    output logic              reg_write_mw,
    output logic [REG_W-1:0]  register_d_mw,
    output logic              stall_m,
    output logic              misalign_m,
    output logic              bus_error_m
);

    mem_state_t        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] rd_buf;
    logic              err_q;

    logic [LANE_W-1:0] lane;
    logic              mem_op;
    logic              misaligned;
    logic              access;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout;
    logic [DATA_W-1:0] align_src;
    logic [DATA_W-1:0] aligned;

    assign lane       = alu_out_m[1:0];
    assign mem_op     = mem_read_m | mem_write_m;
    assign misaligned = mem_op & is_misaligned(mem_size_m, lane);
    assign access     = mem_op & ~misaligned;
    // Timeout fires on the WAIT cycle that would bring the count to the limit.
    assign cnt_inc    = wait_cnt + CNT_W'(1);
    assign timeout    = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // Single aligner: direct-ack loads use the bus word, DONE uses the buffer.
    assign align_src  = (state == ST_DONE) ? rd_buf : dmem_rdata;

    mem_load_align u_align (
        .rdata       (align_src),
        .lane        (lane),
        .size        (mem_size_m),
        .is_unsigned (mem_unsigned_m),
        .aligned_c   (aligned)
    );

    // Request fields follow EX/MEM directly; it is frozen while we wait.
    assign dmem_addr     = {alu_out_m[ADDR_W-1:2], 2'b00};
    assign dmem_we       = mem_write_m;
    assign dmem_be       = byte_enable(mem_size_m, lane);
    assign alu_out_mw    = alu_out_m;
    assign wb_source_mw  = wb_source_m;
    assign register_d_mw = register_d_m;

    always_comb begin
        dmem_wdata = write_data_m;
        if (mem_size_m == SIZE_BYTE) begin
            dmem_wdata = {4{write_data_m[7:0]}};
        end else if (mem_size_m == SIZE_HALF) begin
            dmem_wdata = {2{write_data_m[15:0]}};
        end
    end

    // Handshake state, wait counter, read buffer and bus-error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            rd_buf   <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    err_q    <= 1'b0;
                    if (access && !dmem_ack) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Ack wins over a coincident timeout.
                    if (dmem_ack) begin
                        rd_buf <= dmem_rdata;
                        err_q  <= 1'b0;
                        state  <= ST_DONE;
                    end else if (timeout) begin
                        rd_buf <= '0;
                        err_q  <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end
                ST_DONE: begin
                    wait_cnt <= '0;
                    err_q    <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake and MEM/WB write-back outputs by state.
    always_comb begin
        dmem_req     = 1'b0;
        stall_m      = 1'b0;
        misalign_m   = 1'b0;
        bus_error_m  = 1'b0;
        reg_write_mw = 1'b0;
        data_mw      = '0;
        unique case (state)
            ST_IDLE: begin
                misalign_m = misaligned;
                if (access) begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        reg_write_mw = reg_write_m & ~mem_write_m;
                        data_mw      = mem_read_m ? aligned : '0;
                    end else begin
                        stall_m = 1'b1;
                    end
                end else if (!mem_op) begin
                    reg_write_mw = reg_write_m;
                end
            end
            ST_WAIT: begin
                dmem_req = 1'b1;
                stall_m  = 1'b1;
            end
            ST_DONE: begin
                bus_error_m  = err_q;
                reg_write_mw = reg_write_m & ~mem_write_m & ~err_q;
                data_mw      = mem_read_m ? aligned : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// randomized loads/stores/ALU ops with random ack latencies, checked against
// a transaction-level reference model.
module tb_mem_access_stage;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_out_m, write_data_m, dmem_rdata;
    logic        mem_read_m, mem_write_m, mem_unsigned_m, wb_source_m, reg_write_m, dmem_ack;
    logic [1:0]  mem_size_m;
    logic [4:0]  register_d_m;
    logic        dmem_req, dmem_we, wb_source_mw, reg_write_mw, stall_m, misalign_m, bus_error_m;
    logic [31:0] dmem_addr, dmem_wdata, alu_out_mw, data_mw;
    logic [3:0]  dmem_be;
    logic [4:0]  register_d_mw;

    int vectors = 0;
    int miscompares = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .alu_out_m(alu_out_m), .write_data_m(write_data_m),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .mem_size_m(mem_size_m), .mem_unsigned_m(mem_unsigned_m),
        .wb_source_m(wb_source_m), .reg_write_m(reg_write_m),
        .register_d_m(register_d_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .alu_out_mw(alu_out_mw), .data_mw(data_mw), .wb_source_mw(wb_source_mw),
        .reg_write_mw(reg_write_mw), .register_d_mw(register_d_mw),
        .stall_m(stall_m), .misalign_m(misalign_m), .bus_error_m(bus_error_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: an access covers nb bytes starting at its byte offset.
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
        int nb;
        logic [31:0] v;
        nb = nbytes(size);
        v  = word >> (8 * int'(addr[1:0]));
        if (nb == 1) begin
            v = v & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (nb == 2) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] addr, input logic [1:0] size);
        logic [3:0] be;
        int start;
        start = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) be[i] = (i >= start) && (i < start + nbytes(size));
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] data, input logic [1:0] size);
        logic [31:0] w;
        int nb;
        nb = nbytes(size);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % nb) +: 8];
        return w;
    endfunction

    task automatic drive_idle();
        alu_out_m = 32'd0; write_data_m = 32'd0; mem_read_m = 1'b0; mem_write_m = 1'b0;
        mem_size_m = 2'd0; mem_unsigned_m = 1'b0; wb_source_m = 1'b0; reg_write_m = 1'b0;
        register_d_m = 5'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    endtask

    // One EX/MEM instruction. op: 0=ALU, 1=load, 2=store. ack_k is the request
    // cycle (0 = the first) in which memory acks; negative means never.
    // Call just after a rising edge; returns just after a rising edge.
    task automatic run_op(input int op, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic rw, input logic [4:0] rd,
                          input logic wbs, input int ack_k);
        bit mis, ok, zero_lat, fin;
        int done;
        logic [31:0] exp_rw;
        mis = (op != 0) && ((int'(addr[1:0]) % nbytes(size)) != 0);
        alu_out_m = addr; write_data_m = wdata; mem_size_m = size; mem_unsigned_m = uns;
        mem_read_m = (op == 1); mem_write_m = (op == 2); reg_write_m = rw;
        register_d_m = rd; wb_source_m = wbs;
        if (op == 0 || mis) begin
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            @(negedge clk);
            check("pass_req",   32'(dmem_req), 32'd0);
            check("pass_stall", 32'(stall_m), 32'd0);
            check("pass_mis",   32'(misalign_m), 32'(mis));
            check("pass_rw",    32'(reg_write_mw), (op == 0) ? 32'(rw) : 32'd0);
            check("pass_alu",   alu_out_mw, addr);
            check("pass_rd",    32'(register_d_mw), 32'(rd));
            @(posedge clk); #1;
            return;
        end
        ok       = (ack_k >= 0) && (ack_k <= int'(TO));
        zero_lat = ok && (ack_k == 0);
        done     = !ok ? int'(TO) + 1 : (zero_lat ? 0 : ack_k + 1);
        exp_rw   = (ok && op == 1 && rw) ? 32'd1 : 32'd0;
        for (int c = 0; c <= done; c++) begin
            fin = (c == done);
            dmem_ack   = (c == ack_k);
            dmem_rdata = (c == ack_k) ? rdata : $urandom;
            @(negedge clk);
            check("req",   32'(dmem_req), (zero_lat || c < done) ? 32'd1 : 32'd0);
            check("stall", 32'(stall_m),  (!zero_lat && c < done) ? 32'd1 : 32'd0);
            check("mis",   32'(misalign_m), 32'd0);
            check("berr",  32'(bus_error_m), (fin && !ok) ? 32'd1 : 32'd0);
            check("rw",    32'(reg_write_mw), fin ? exp_rw : 32'd0);
            if (c == 0) begin
                check("addr", dmem_addr, addr & 32'hFFFF_FFFC);
                check("we",   32'(dmem_we), (op == 2) ? 32'd1 : 32'd0);
                check("be",   32'(dmem_be), 32'(ref_be(addr, size)));
                if (op == 2) check("wdata", dmem_wdata, ref_wdata(wdata, size));
            end
            if (fin) check("data", data_mw, (ok && op == 1) ? ref_load(rdata, addr, size, uns) : 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int op, k, r;
        logic [1:0] sz;
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",   32'(dmem_req), 32'd0);
        check("rst_stall", 32'(stall_m), 32'd0);
        check("rst_data",  data_mw, 32'd0);
        check("rst_rw",    32'(reg_write_mw), 32'd0);
        check("rst_berr",  32'(bus_error_m), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // lw with same-cycle ack
        run_op(1, 2'd2, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 1'b1, 5'd3, 1'b1, 0);
        // lb / lbu with ack in the third request cycle
        run_op(1, 2'd0, 1'b0, 32'h103, 32'd0, 32'h80FF0000, 1'b1, 5'd4, 1'b1, 2);
        run_op(1, 2'd0, 1'b1, 32'h103, 32'd0, 32'h80FF0000, 1'b1, 5'd4, 1'b1, 2);
        // sh to the upper half
        run_op(2, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 32'd0, 1'b1, 5'd0, 1'b0, 0);
        // misaligned lw
        run_op(1, 2'd2, 1'b0, 32'h101, 32'd0, 32'd0, 1'b1, 5'd5, 1'b1, 0);
        // ALU passthrough
        run_op(0, 2'd0, 1'b0, 32'hCAFE0001, 32'd0, 32'd0, 1'b1, 5'd9, 1'b0, 0);
        // timeout, and ack coinciding with the last allowed WAIT cycle
        run_op(1, 2'd2, 1'b0, 32'h200, 32'd0, 32'h11111111, 1'b1, 5'd6, 1'b1, -1);
        run_op(1, 2'd2, 1'b0, 32'h204, 32'd0, 32'h22222222, 1'b1, 5'd6, 1'b1, int'(TO));
        // lh sign-extension, reserved size acts as word
        run_op(1, 2'd1, 1'b0, 32'h302, 32'd0, 32'h8001_7FFF, 1'b1, 5'd7, 1'b1, 1);
        run_op(1, 2'd3, 1'b0, 32'h308, 32'd0, 32'h0BAD_F00D, 1'b1, 5'd7, 1'b1, 0);

        // reset during the second WAIT cycle
        alu_out_m = 32'h400; mem_read_m = 1'b1; mem_size_m = 2'd2; reg_write_m = 1'b1;
        dmem_ack = 1'b0;
        @(negedge clk); check("rw_c0_req", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); check("rw_c1_stall", 32'(stall_m), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_req",   32'(dmem_req), 32'd0);
        check("rst_mid_stall", 32'(stall_m), 32'd0);
        @(posedge clk); #1;
        // a full-length wait afterwards only succeeds if the counter restarted at 0
        run_op(1, 2'd2, 1'b0, 32'h404, 32'd0, 32'h5A5A5A5A, 1'b1, 5'd8, 1'b1, int'(TO));

        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 2);
            sz = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 5);
            k  = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? $urandom_range(2, TO - 1) :
                 (r == 3) ? int'(TO) : (r == 4) ? -1 : int'(TO) + 1;
            run_op(op, sz, 1'($urandom), $urandom, $urandom, $urandom,
                   1'($urandom), 5'($urandom), 1'($urandom), k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
